// File: rtl/bp_perf_pkg.sv
// Shared types and constants for the branch-prediction performance monitor.
// Optional feature macro: BP_PERF_STREAK_EN (adds the max-mispredict-streak word).
package bp_perf_pkg;

  // Dump FSM states
  typedef enum logic {
    BP_PERF_IDLE = 1'b0,
    BP_PERF_SEND = 1'b1
  } bp_perf_state_e;

  // Position of each counter in the dump stream
  typedef enum logic [2:0] {
    BP_PERF_W_CYC    = 3'd0,
    BP_PERF_W_INSN   = 3'd1,
    BP_PERF_W_BR     = 3'd2,
    BP_PERF_W_MISS   = 3'd3,
    BP_PERF_W_STREAK = 3'd4
  } bp_perf_word_e;

`ifdef BP_PERF_STREAK_EN
  localparam int unsigned BP_PERF_NUM_WORDS = 5;
`else
  localparam int unsigned BP_PERF_NUM_WORDS = 4;
`endif

  // Index of the word that carries dump_last_o
  localparam bp_perf_word_e BP_PERF_LAST_WORD =
    bp_perf_word_e'(3'(BP_PERF_NUM_WORDS - 1));

endpackage

// File: rtl/bp_sat_counter.sv
// Saturating up-counter with synchronous clear.
// value_o is the count as it will be after this edge (register input), so a
// snapshot taken on the same edge includes this cycle's event.
module bp_sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] value_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Clear wins over increment; increment stops at all-ones instead of wrapping
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  // Count register with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value_o = cnt_d;

endmodule

// File: rtl/bp_perf_monitor.sv
// Branch-prediction performance monitor: live saturating event counters plus a
// snapshot-and-stream dump over a valid/ready word interface.
// Optional feature macro: BP_PERF_STREAK_EN (longest run of consecutive
// mispredicted branches, sent as a fifth dump word).
module bp_perf_monitor
  import bp_perf_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic                 clr_i,
  input  logic                 insn_vld_i,
  input  logic                 br_instr_i,
  input  logic                 br_miss_i,
  input  logic                 dump_start_i,
  input  logic                 dump_rdy_i,
  output logic                 dump_vld_o,
  output logic [CNT_WIDTH-1:0] dump_data_o,
  output logic                 dump_last_o,
  output logic                 busy_o
);

  bp_perf_state_e state_q, state_d;
  bp_perf_word_e  idx_q, idx_d;

  logic [CNT_WIDTH-1:0] cyc_d, insn_d, br_d, miss_d;
  logic [CNT_WIDTH-1:0] snapCyc_q, snapInsn_q, snapBr_q, snapMiss_q;
  logic                 snapLoad;

  assign snapLoad = (state_q == BP_PERF_IDLE) && dump_start_i;

  bp_sat_counter #(.WIDTH(CNT_WIDTH)) u_cyc (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (clr_i),
    .en_i    (en_i),
    .inc_i   (1'b1),
    .value_o (cyc_d)
  );

  bp_sat_counter #(.WIDTH(CNT_WIDTH)) u_insn (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (clr_i),
    .en_i    (en_i),
    .inc_i   (insn_vld_i),
    .value_o (insn_d)
  );

  bp_sat_counter #(.WIDTH(CNT_WIDTH)) u_br (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (clr_i),
    .en_i    (en_i),
    .inc_i   (br_instr_i),
    .value_o (br_d)
  );

  bp_sat_counter #(.WIDTH(CNT_WIDTH)) u_miss (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (clr_i),
    .en_i    (en_i),
    .inc_i   (br_instr_i & br_miss_i),
    .value_o (miss_d)
  );

`ifdef BP_PERF_STREAK_EN
  logic [CNT_WIDTH-1:0] streakCur_d;
  logic [CNT_WIDTH-1:0] streakMax_q, streakMax_d;
  logic [CNT_WIDTH-1:0] snapStreak_q;
  logic                 streakHit;

  // A correctly predicted branch breaks the current run of misses
  assign streakHit = en_i & br_instr_i & ~br_miss_i;

  bp_sat_counter #(.WIDTH(CNT_WIDTH)) u_streakCur (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (clr_i | streakHit),
    .en_i    (en_i),
    .inc_i   (br_instr_i & br_miss_i),
    .value_o (streakCur_d)
  );

  // Track the longest run seen, comparing against the post-update run length
  always_comb begin
    streakMax_d = streakMax_q;
    if (clr_i) begin
      streakMax_d = '0;
    end else if (streakCur_d > streakMax_q) begin
      streakMax_d = streakCur_d;
    end
  end

  // Max-streak register and its snapshot copy
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      streakMax_q  <= '0;
      snapStreak_q <= '0;
    end else begin
      streakMax_q <= streakMax_d;
      if (snapLoad) begin
        snapStreak_q <= streakMax_d;
      end
    end
  end
`endif

  // Snapshot captures post-update counts so same-cycle events are included
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      snapCyc_q  <= '0;
      snapInsn_q <= '0;
      snapBr_q   <= '0;
      snapMiss_q <= '0;
    end else if (snapLoad) begin
      snapCyc_q  <= cyc_d;
      snapInsn_q <= insn_d;
      snapBr_q   <= br_d;
      snapMiss_q <= miss_d;
    end
  end

  // FSM state and word-index register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= BP_PERF_IDLE;
      idx_q   <= BP_PERF_W_CYC;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next state: a start in IDLE begins at word 0; each accepted word advances
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      BP_PERF_IDLE: begin
        if (dump_start_i) begin
          state_d = BP_PERF_SEND;
          idx_d   = BP_PERF_W_CYC;
        end
      end
      BP_PERF_SEND: begin
        if (dump_rdy_i) begin
          if (idx_q == BP_PERF_LAST_WORD) begin
            state_d = BP_PERF_IDLE;
          end else begin
            idx_d = bp_perf_word_e'(idx_q + 3'd1);
          end
        end
      end
      default: begin
        state_d = BP_PERF_IDLE;
      end
    endcase
  end

  // Outputs depend only on registered state, never on dump_rdy_i
  always_comb begin
    dump_vld_o  = 1'b0;
    busy_o      = 1'b0;
    dump_last_o = 1'b0;
    dump_data_o = '0;
    if (state_q == BP_PERF_SEND) begin
      dump_vld_o  = 1'b1;
      busy_o      = 1'b1;
      dump_last_o = (idx_q == BP_PERF_LAST_WORD);
      case (idx_q)
        BP_PERF_W_CYC:    dump_data_o = snapCyc_q;
        BP_PERF_W_INSN:   dump_data_o = snapInsn_q;
        BP_PERF_W_BR:     dump_data_o = snapBr_q;
        BP_PERF_W_MISS:   dump_data_o = snapMiss_q;
`ifdef BP_PERF_STREAK_EN
        BP_PERF_W_STREAK: dump_data_o = snapStreak_q;
`endif
        default:          dump_data_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_perf_monitor.sv
// Testbench for bp_perf_monitor: a 32-bit and a 4-bit instance share stimulus
// and are compared every cycle against an event-count model; directed phases
// pin the model with literal expectations. Honours BP_PERF_STREAK_EN.
module tb_bp_perf_monitor;

`ifdef BP_PERF_STREAK_EN
  localparam int NW = 5;
`else
  localparam int NW = 4;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstN, en, clr, insnVld, brInstr, brMiss, dumpStart, dumpRdy;
  logic vldW, lastW, busyW;
  logic [31:0] dataW;
  logic vldN, lastN, busyN;
  logic [3:0] dataN;

  bp_perf_monitor #(.CNT_WIDTH(32)) dutW (
    .clk_i(clk), .rst_ni(rstN), .en_i(en), .clr_i(clr),
    .insn_vld_i(insnVld), .br_instr_i(brInstr), .br_miss_i(brMiss),
    .dump_start_i(dumpStart), .dump_rdy_i(dumpRdy),
    .dump_vld_o(vldW), .dump_data_o(dataW), .dump_last_o(lastW), .busy_o(busyW)
  );

  bp_perf_monitor #(.CNT_WIDTH(4)) dutN (
    .clk_i(clk), .rst_ni(rstN), .en_i(en), .clr_i(clr),
    .insn_vld_i(insnVld), .br_instr_i(brInstr), .br_miss_i(brMiss),
    .dump_start_i(dumpStart), .dump_rdy_i(dumpRdy),
    .dump_vld_o(vldN), .dump_data_o(dataN), .dump_last_o(lastN), .busy_o(busyN)
  );

  int checks = 0;
  int errors = 0;
  bit checkEn = 0;

  // Model: unbounded event counts since last clear, clamped only when compared
  longint mCyc, mInsn, mBr, mMiss, mCur, mMax;
  bit     mSend;
  int     mIdx;
  longint mSnap [5];

  longint gotW [5];
  longint gotN [5];
  int     gotCount, gotLast;

  function automatic longint clampTo(input longint v, input int w);
    longint lim;
    lim = (longint'(1) << w) - 1;
    return (v > lim) ? lim : v;
  endfunction

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model advances on each rising edge from the stimulus inputs
  always @(posedge clk) begin
    if (!rstN) begin
      mCyc = 0; mInsn = 0; mBr = 0; mMiss = 0; mCur = 0; mMax = 0;
      mSend = 0; mIdx = 0;
      for (int i = 0; i < 5; i++) mSnap[i] = 0;
    end else begin
      if (clr) begin
        mCyc = 0; mInsn = 0; mBr = 0; mMiss = 0; mCur = 0; mMax = 0;
      end else if (en) begin
        mCyc++;
        if (insnVld) mInsn++;
        if (brInstr) begin
          mBr++;
          if (brMiss) begin
            mMiss++;
            mCur++;
          end else begin
            mCur = 0;
          end
          if (mCur > mMax) mMax = mCur;
        end
      end
      if (mSend) begin
        if (dumpRdy) begin
          if (mIdx == NW - 1) mSend = 0;
          else mIdx++;
        end
      end else if (dumpStart) begin
        mSend = 1;
        mIdx = 0;
        mSnap[0] = mCyc; mSnap[1] = mInsn; mSnap[2] = mBr;
        mSnap[3] = mMiss; mSnap[4] = mMax;
      end
    end
  end

  // Compare both instances against the model on every falling edge
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("vldW",  longint'(vldW),  longint'(mSend));
      checkOutput("busyW", longint'(busyW), longint'(mSend));
      checkOutput("lastW", longint'(lastW), longint'(mSend && (mIdx == NW - 1)));
      checkOutput("dataW", longint'(dataW), mSend ? clampTo(mSnap[mIdx], 32) : 0);
      checkOutput("vldN",  longint'(vldN),  longint'(mSend));
      checkOutput("busyN", longint'(busyN), longint'(mSend));
      checkOutput("lastN", longint'(lastN), longint'(mSend && (mIdx == NW - 1)));
      checkOutput("dataN", longint'(dataN), mSend ? clampTo(mSnap[mIdx], 4) : 0);
    end
  end

  // Drive one cycle of inputs, then move to 1 time unit after the next edge
  task automatic applyStimulus(input bit r, input bit e, input bit c, input bit iv,
                               input bit bi, input bit bm, input bit ds, input bit dr);
    rstN = r; en = e; clr = c; insnVld = iv;
    brInstr = bi; brMiss = bm; dumpStart = ds; dumpRdy = dr;
    @(posedge clk);
    #1;
  endtask

  // Optionally start a dump, then drain it with ready high (bounded)
  task automatic dumpWords(input bit doStart);
    bit done;
    done = 0;
    gotCount = 0;
    gotLast = -1;
    for (int i = 0; i < 5; i++) begin
      gotW[i] = -1;
      gotN[i] = -1;
    end
    if (doStart) applyStimulus(1, 0, 0, 0, 0, 0, 1, 1);
    for (int k = 0; k < 20 && !done; k++) begin
      if (vldW && gotCount < 5) begin
        gotW[gotCount] = dataW;
        gotN[gotCount] = dataN;
        if (lastW) begin
          gotLast = gotCount;
          done = 1;
        end
        gotCount++;
      end
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
    end
    checkOutput("dumpWordCount", gotCount, NW);
    checkOutput("dumpLastIndex", gotLast, NW - 1);
  endtask

  initial begin
    bit r, e, c, iv, bi, bm, ds, dr;

    // Reset
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkEn = 1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("resetVld",  longint'(vldW),  0);
    checkOutput("resetBusy", longint'(busyW), 0);
    checkOutput("resetLast", longint'(lastW), 0);
    checkOutput("resetData", longint'(dataW), 0);

    // 10 enabled cycles, 6 instructions, 4 branches with 1 miss
    for (int i = 0; i < 10; i++)
      applyStimulus(1, 1, 0, i < 6, (i % 2 == 0) && (i < 8), i == 2, 0, 0);
    dumpWords(1);
    checkOutput("basicCyc",  gotW[0], 10);
    checkOutput("basicInsn", gotW[1], 6);
    checkOutput("basicBr",   gotW[2], 4);
    checkOutput("basicMiss", gotW[3], 1);
`ifdef BP_PERF_STREAK_EN
    checkOutput("basicStreak", gotW[4], 1);
`endif

    // Miss without a branch is ignored
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, 0, 0, 0, 1, 0, 0);
    dumpWords(1);
    checkOutput("strayMissCyc", gotW[0], 5);
    checkOutput("strayMissBr",  gotW[2], 0);
    checkOutput("strayMissMiss", gotW[3], 0);

    // Saturation on the narrow instance
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    dumpWords(1);
    checkOutput("satWideCyc",   gotW[0], 20);
    checkOutput("satNarrowCyc", gotN[0], 15);

    // Backpressure with clear and a second start mid-dump
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("heldData", longint'(dataW), 7);
      applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    end
    applyStimulus(1, 1, 1, 0, 0, 0, 1, 0);
    checkOutput("heldAfterClr", longint'(dataW), 7);
    dumpWords(0);
    checkOutput("heldWord0", gotW[0], 7);
    checkOutput("heldWord1", gotW[1], 0);
    dumpWords(1);
    checkOutput("postClrCyc", gotW[0], 0);

    // Streak sequence: miss, miss, miss, hit, miss, miss
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) applyStimulus(1, 1, 0, 0, 1, i != 3, 0, 0);
    dumpWords(1);
    checkOutput("streakBr",   gotW[2], 6);
    checkOutput("streakMiss", gotW[3], 5);
`ifdef BP_PERF_STREAK_EN
    checkOutput("streakMax", gotW[4], 3);
`endif

    // Reset during word 2 of a dump
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 1, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("midWord2", longint'(dataW), 4);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("rstVld",  longint'(vldW),  0);
    checkOutput("rstBusy", longint'(busyW), 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    dumpWords(1);
    checkOutput("rstCyc",  gotW[0], 3);
    checkOutput("rstInsn", gotW[1], 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 199) != 0);
      e  = ($urandom_range(0, 99) < 85);
      c  = ($urandom_range(0, 99) < 3);
      iv = ($urandom_range(0, 1) == 1);
      bi = ($urandom_range(0, 99) < 40);
      bm = ($urandom_range(0, 1) == 1);
      ds = ($urandom_range(0, 99) < 10);
      dr = ($urandom_range(0, 99) < 70);
      applyStimulus(r, e, c, iv, bi, bm, ds, dr);
    end
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    #1;
    checkEn = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_perf_monitor.md
# bp_perf_monitor

Branch-prediction performance monitor sitting beside any pipelined predictor core (always-taken, two-bit, gshare, agree variants). It consumes the core's per-cycle resolution strobes. It accumulates saturating event counters for cycles, valid instructions, resolved branches and mispredictions. On request, it snapshots all counters and streams them out over a valid/ready word interface for the bench or a debug port.

## Interface
- `CNT_WIDTH`, default 32: width of every counter and of the dump word.
- `clk_i`  in  1  core clock.
- `rst_ni`  in  1  reset; synchronous, active-low.
- `en_i`  in  1  counting enable; when low, live counters hold.
- `clr_i`  in  1  synchronous clear of live counters.
- `insn_vld_i`  in  1  a valid instruction retired this cycle.
- `br_instr_i`  in  1  a branch/jump resolved in EX/MEM this cycle.
- `br_miss_i`  in  1  the resolving branch was mispredicted; it is only meaningful with `br_instr_i`.
- `dump_start_i`  in  1  request a snapshot-and-dump.
- `dump_rdy_i`  in  1  sink ready.
- `dump_vld_o`  out  1  dump word valid.
- `dump_data_o`  out  CNT_WIDTH  dump word.
- `dump_last_o`  out  1  current word is the final one.
- `busy_o`  out  1  dump in progress.

## Operation
- Live counters:
  - `cyc` increments every cycle with `en_i`.
  - `insn` increments on `insn_vld_i`.
  - `br` increments on `br_instr_i`.
  - `miss` increments on `br_instr_i && br_miss_i`.
  - `br_miss_i` without `br_instr_i` is ignored.
- All counters saturate at all-ones and never wrap.
- `clr_i` has priority over every increment in the same cycle; the counter becomes 0.
- `clr_i` does not affect an in-flight snapshot.
- FSM states are IDLE and SEND.
  - IDLE → SEND on `dump_start_i`. On that edge the snapshot registers capture the live counter values, including any increment occurring in the same cycle. The word index resets to 0.
  - SEND advances the index on `dump_vld_o && dump_rdy_i`.
  - SEND → IDLE on the handshake of the last word.
  - `dump_start_i` while in SEND is ignored.
- Word order: 0 cyc, 1 insn, 2 br, 3 miss, then 4 max-streak when `BP_PERF_STREAK_EN` is defined.
- `dump_data_o` is held stable while `dump_vld_o && !dump_rdy_i`.
- Live counting continues during SEND.
- Reset values: all counters and snapshots 0, state IDLE, and `dump_vld_o`, `dump_last_o` and `busy_o` all 0. `dump_data_o` is 0 in IDLE.
- Reset mid-dump: the FSM returns to IDLE, `dump_vld_o` drops next edge, and the partial dump is discarded.

## Timing
- Counter update latency: 1 cycle. An event in cycle N is visible in the live count after edge N.
- Dump start in cycle N (IDLE) → `busy_o` and `dump_vld_o` high from cycle N+1 with word 0.
- With `dump_rdy_i` held high, one word is emitted per cycle. `dump_last_o` is high on word NUM_WORDS-1.
- `busy_o` is low in the cycle after the final handshake. A new `dump_start_i` is accepted in that cycle.
- `dump_vld_o` never depends combinationally on `dump_rdy_i`.

## Configuration
- `BP_PERF_STREAK_EN` defined:
  - adds a current-streak register, which increments (saturating) on a mispredicted branch and resets to 0 on a correctly predicted branch;
  - adds a max-streak register, updated whenever current exceeds max;
  - `clr_i` zeroes both registers;
  - the dump has 5 words.
- `BP_PERF_STREAK_EN` undefined: no streak logic, and the dump has 4 words. `dump_last_o` asserts on word 3.

## Structure
- Package `bp_perf_pkg` holds:
  - the FSM state enum (`BP_PERF_IDLE`, `BP_PERF_SEND`);
  - the word-index enum;
  - `BP_PERF_NUM_WORDS`, conditional on `BP_PERF_STREAK_EN`.
- Sub-module `bp_sat_counter`, parameterised by width, with inputs clear, increment and enable, and a saturating value output. It is instantiated once per counter.

## Test plan
- Reset, then 10 cycles with `en_i=1`, `insn_vld_i=1` for 6 cycles, and 4 branches of which 1 misses; then dump with `dump_rdy_i=1` → words 10, 6, 4, 1 on consecutive cycles, with `dump_last_o` on word 3 (word 4 instead if `BP_PERF_STREAK_EN`).
- `br_miss_i=1` with `br_instr_i=0` for 5 cycles → miss stays 0 and br stays 0.
- `CNT_WIDTH=4`, 20 enabled cycles → dumped cyc = 15 (saturated, no wrap).
- Start a dump, hold `dump_rdy_i=0` for 3 cycles, assert `clr_i` and `dump_start_i` mid-dump → word 0 is held stable with the original snapshot value, the extra start is ignored, and the next dump shows cleared counts.
- `BP_PERF_STREAK_EN`: branch outcome sequence miss, miss, miss, hit, miss, miss → max-streak word = 3.
- Assert `rst_ni=0` during SEND word 2 → next cycle `dump_vld_o=0` and `busy_o=0`, and a subsequent dump reports counts from 0.
